// File: rtl/pe_array.sv
`default_nettype none
// ============================================================================
//  Module   : pe_array
//  Purpose  : Weight-stationary systolic MAC array. A ROWS x COLS grid of
//             processing elements. Weights shift in top-down under
//             load_weight and are then held. Activations stream left-to-right,
//             one lane per row. Partial sums flow top-to-bottom and leave the
//             bottom row, one result per column per cycle.
//  Ports    : clk          - clock, all state updates on the rising edge
//             rst_n        - asynchronous reset, active low, clears all PE state
//             iacts        - per-row activation entering column 0
//             weights      - per-column weight entering row 0
//             load_weight  - weight shift enable
//             psums        - bottom-row partial sum per column
//  Config   : PE_ARRAY_SIGNED_EN - when defined, operands and results are two's
//             complement and products are sign-extended. When undefined, all
//             arithmetic is unsigned with zero-extended products.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_array #(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int IACT_W = 32,
  parameter int WGT_W  = 16,
  parameter int PSUM_W = 48
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [0:ROWS-1][IACT_W-1:0]    iacts,
  input  logic [0:COLS-1][WGT_W-1:0]     weights,
  input  logic                           load_weight,
  output logic [0:COLS-1][PSUM_W-1:0]    psums
);

  // Per-PE register values gathered into grids so neighbours can read them.
  // Each element is driven by exactly one PE instance.
  logic [WGT_W-1:0]  weight_q [ROWS][COLS];
  logic [IACT_W-1:0] iact_q   [ROWS][COLS];
  logic [PSUM_W-1:0] psum_q   [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [WGT_W-1:0]  weight_in;
      logic [IACT_W-1:0] iact_in;
      logic [PSUM_W-1:0] psum_in;
      logic [PSUM_W-1:0] product;
      logic [WGT_W-1:0]  weight_reg;
      logic [IACT_W-1:0] iact_reg;
      logic [PSUM_W-1:0] psum_reg;

      // Top row takes the external weight lane and starts the sum at zero.
      if (r == 0) begin : g_top
        assign weight_in = weights[c];
        assign psum_in   = '0;
      end else begin : g_below
        assign weight_in = weight_q[r-1][c];
        assign psum_in   = psum_q[r-1][c];
      end

      // Left column takes the external activation lane.
      if (c == 0) begin : g_left
        assign iact_in = iacts[r];
      end else begin : g_right
        assign iact_in = iact_q[r][c-1];
      end

      // Operands are widened to the sum width before multiplying; the low
      // PSUM_W bits of the widened product equal the extended full product,
      // so the accumulation wraps naturally modulo 2^PSUM_W.
`ifdef PE_ARRAY_SIGNED_EN
      logic signed [PSUM_W-1:0] iact_ext;
      logic signed [PSUM_W-1:0] weight_ext;
      assign iact_ext   = PSUM_W'($signed(iact_in));
      assign weight_ext = PSUM_W'($signed(weight_reg));
`else
      logic [PSUM_W-1:0] iact_ext;
      logic [PSUM_W-1:0] weight_ext;
      assign iact_ext   = PSUM_W'(iact_in);
      assign weight_ext = PSUM_W'(weight_reg);
`endif
      assign product = iact_ext * weight_ext;

      // MAC runs every cycle regardless of load_weight; whatever weight is
      // currently held is used.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          weight_reg <= '0;
          iact_reg   <= '0;
          psum_reg   <= '0;
        end else begin
          if (load_weight) begin
            weight_reg <= weight_in;
          end
          iact_reg <= iact_in;
          psum_reg <= psum_in + product;
        end
      end

      assign weight_q[r][c] = weight_reg;
      assign iact_q[r][c]   = iact_reg;
      assign psum_q[r][c]   = psum_reg;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign psums[c] = psum_q[ROWS-1][c];
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_array
//  Purpose  : Self-checking bench for pe_array. Stimulus updates a reference
//             model that predicts each column's output from the history of
//             driven activations and the weight matrix in force on each cycle;
//             predictions are queued and a monitor compares them against the
//             DUT one cycle at a time. Directed checks cover reset, the
//             reference matmul, wraparound and mid-stream async reset.
//  Config   : PE_ARRAY_SIGNED_EN selects the signed reference arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_array;
  localparam int ROWS   = 3;
  localparam int COLS   = 3;
  localparam int IACT_W = 32;
  localparam int WGT_W  = 16;
  localparam int PSUM_W = 48;
  localparam int MAXN   = 2048;

  typedef logic [0:COLS-1][PSUM_W-1:0]          pvec_t;
  typedef logic [0:COLS-1][WGT_W-1:0]           wvec_t;
  typedef logic [0:ROWS-1][0:COLS-1][WGT_W-1:0] wmat_t;
  typedef logic [0:ROWS-1][IACT_W-1:0]          avec_t;

  logic  clk;
  logic  rst_n;
  avec_t iacts;
  wvec_t weights;
  logic  load_weight;
  pvec_t psums;

  pe_array #(
    .ROWS(ROWS), .COLS(COLS), .IACT_W(IACT_W), .WGT_W(WGT_W), .PSUM_W(PSUM_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iacts(iacts),
    .weights(weights),
    .load_weight(load_weight),
    .psums(psums)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (since last reset release)
  wvec_t loads[$];     // every weight vector loaded, in load order
  avec_t xh[MAXN];     // activations driven on cycle n
  wmat_t wh[MAXN];     // weight matrix in force during cycle n
  int    n = 0;
  pvec_t exp_q[$];

  function automatic logic [PSUM_W-1:0] mul(logic [IACT_W-1:0] a, logic [WGT_W-1:0] w);
`ifdef PE_ARRAY_SIGNED_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(w));
`else
    longint unsigned p;
    p = longint'(a) * longint'(w);
`endif
    return p[PSUM_W-1:0];
  endfunction

  // Row r holds the vector loaded (ROWS-1-r)... i.e. the r-th most recent load.
  function automatic wmat_t cur_wmat();
    wmat_t m;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int idx;
        idx = loads.size() - 1 - r;
        m[r][c] = (idx >= 0) ? loads[idx][c] : '0;
      end
    end
    return m;
  endfunction

  // Output after edge t: column c sums, over rows, the product formed by row r
  // on cycle t-(ROWS-1-r) with the activation that entered row r c cycles earlier.
  function automatic pvec_t model_out(int t);
    pvec_t o;
    for (int c = 0; c < COLS; c++) begin
      logic [PSUM_W-1:0] acc;
      acc = '0;
      for (int r = 0; r < ROWS; r++) begin
        int m;
        int a;
        m = t - (ROWS - 1 - r);
        a = m - c;
        if (a >= 0) acc = acc + mul(xh[a][r], wh[m][r][c]);
      end
      o[c] = acc;
    end
    return o;
  endfunction

  task automatic model_reset();
    loads.delete();
    exp_q.delete();
    n = 0;
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    pvec_t e;
    if (n >= MAXN) begin
      $display("FAIL model_history: n=%0d exceeds required max %0d", n, MAXN);
      $fatal(1);
    end
    xh[n] = iacts;
    wh[n] = cur_wmat();
    e = model_out(n);
    @(posedge clk);
    exp_q.push_back(e);
    if (load_weight) loads.push_back(weights);
    n++;
    #1;
  endtask

  task automatic chk(string name, logic [PSUM_W-1:0] act, logic [PSUM_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_zero(string name);
    for (int c = 0; c < COLS; c++) chk($sformatf("%s_c%0d", name, c), psums[c], '0);
  endtask

  task automatic load3(wvec_t v0, wvec_t v1, wvec_t v2);
    iacts = '0;
    load_weight = 1'b1;
    weights = v0; step();
    weights = v1; step();
    weights = v2; step();
    load_weight = 1'b0;
    weights = '0;
  endtask

  task automatic load_ref_weights();
    load3({16'd7, 16'd4, 16'd1}, {16'd8, 16'd5, 16'd2}, {16'd9, 16'd6, 16'd3});
  endtask

  // Scoreboard monitor: one prediction per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      pvec_t e;
      e = exp_q.pop_front();
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (psums[c] !== e[c]) begin
          errors++;
          $display("FAIL scoreboard_c%0d @%0t: got %h expected %h", c, $time, psums[c], e[c]);
        end
      end
    end
  end

  // Skewed A = [[1,2,3],[4,5,6],[7,8,9]] against the reference weights.
  task automatic run_matmul(int stop_after);
    avec_t seq[5];
    int    tbl[COLS][3];
    seq[0] = {32'd1, 32'd0, 32'd0};
    seq[1] = {32'd2, 32'd4, 32'd0};
    seq[2] = {32'd3, 32'd5, 32'd7};
    seq[3] = {32'd0, 32'd6, 32'd8};
    seq[4] = {32'd0, 32'd0, 32'd9};
    tbl = '{'{90, 114, 138}, '{54, 69, 84}, '{18, 24, 30}};
    for (int j = 0; j < stop_after; j++) begin
      iacts = (j < 5) ? seq[j] : '0;
      step();
      for (int c = 0; c < COLS; c++) begin
        int k;
        k = j - c - (ROWS - 1);
        if (k >= 0 && k < 3)
          chk($sformatf("matmul_c%0d_k%0d", c, k), psums[c], PSUM_W'(tbl[c][k]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0]       wrap64;
    logic [PSUM_W-1:0] wrap_exp;

    // 1. Reset with busy inputs
    rst_n = 1'b0;
    iacts = {32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF};
    weights = {16'hAAAA, 16'h5555, 16'hFFFF};
    load_weight = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_zero("reset");
    end
    iacts = '0; weights = '0; load_weight = 1'b0;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_zero("post_reset");

    // 2. Weight load then hold for 10 cycles
    load_ref_weights();
    for (int i = 0; i < 10; i++) step();

    // 3. Reference matmul
    run_matmul(12);

    // 4. Wraparound
    load3({COLS{16'hFFFF}}, {COLS{16'hFFFF}}, {COLS{16'hFFFF}});
    iacts = {ROWS{32'hFFFF_FFFF}};
`ifdef PE_ARRAY_SIGNED_EN
    wrap_exp = PSUM_W'(3);
`else
    wrap64 = ((64'd1 << 48) - (64'd1 << 32) - (64'd1 << 16) + 64'd1) * 64'd3;
    wrap_exp = wrap64[PSUM_W-1:0];
`endif
    for (int i = 0; i < 8; i++) begin
      step();
      if (i >= 5)
        for (int c = 0; c < COLS; c++) chk($sformatf("wrap_c%0d", c), psums[c], wrap_exp);
    end
    iacts = '0;
    for (int i = 0; i < 6; i++) step();

    // 5. Async reset mid-stream
    load_ref_weights();
    run_matmul(4);
    iacts = {32'd0, 32'd6, 32'd8};
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_zero("async_reset_now");
    @(posedge clk); #1;
    chk_zero("async_reset_hold");
    iacts = '0;
    model_reset();
    #1 rst_n = 1'b1;
    iacts = {32'd0, 32'd0, 32'd9};
    for (int i = 0; i < 5; i++) begin
      iacts = (i == 0) ? iacts : '0;
      step();
    end
    chk_zero("weights_cleared");
    load_ref_weights();
    run_matmul(12);

`ifdef PE_ARRAY_SIGNED_EN
    // 6. Signed: -1 in PE(0,0) only, iact 5
    load3({16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd0}, {16'hFFFF, 16'd0, 16'd0});
    for (int j = 0; j < 6; j++) begin
      iacts = (j == 0) ? {32'd5, 32'd0, 32'd0} : '0;
      step();
      if (j == 2) chk("signed_neg5", psums[0], 48'hFFFF_FFFF_FFFB);
    end
`endif

    // Randomized traffic, including weight loads during streaming
    for (int i = 0; i < 300; i++) begin
      load_weight = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < COLS; c++) weights[c] = WGT_W'($urandom);
      for (int r = 0; r < ROWS; r++)
        iacts[r] = ($urandom_range(0, 1) == 0) ? IACT_W'($urandom_range(0, 255)) : IACT_W'($urandom);
      step();
    end
    load_weight = 1'b0;
    iacts = '0;
    weights = '0;
    for (int i = 0; i < 6; i++) step();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
